cpu_commit_stage: RTL and testbench

- Memory/commit stage of the in-order pipeline. It consumes the execute-to-commit bundle: commit controls, writeback controls, add_result, alu_result, zero, rb and reg_dest.
- It performs the data-memory access over a req/ack handshake and resolves branches.
- It registers the writeback bundle for the writeback stage.
- It back-pressures execute while a memory access is outstanding.

---
 rtl/cpu_commit_stage_pkg.sv | 33 +++
 rtl/cpu_mem_wb_reg.sv | 60 ++++++
 rtl/cpu_commit_stage.sv | 210 +++++++++++++++++++++
 tb/tb_cpu_commit_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_commit_stage_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared types and width constants for the commit (memory) stage of the
//   in-order pipeline.
//
//   commit_t     : commit controls carried from execute {branch, mem_write, mem_read}
//   writeback_t  : writeback controls carried from execute {mem_to_reg, reg_write}
//   mem_state_e  : memory-stage FSM state {IDLE, MEM_WAIT}
//   Width constants: VIRTUAL_ADDR_WIDTH, REG_WIDTH, NUM_REGS
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int VIRTUAL_ADDR_WIDTH = 32;
    localparam int REG_WIDTH          = 32;
    localparam int NUM_REGS           = 32;

    typedef struct packed {
        logic branch;
        logic mem_write;
        logic mem_read;
    } commit_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } writeback_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage : cpu_pkg

// File: rtl/cpu_mem_wb_reg.sv
// ----------------------------------------------------------------------------
// cpu_mem_wb_reg
//   Registered writeback bundle handed to the writeback stage. o_wb_valid is
//   a one-cycle pulse for every i_load; the payload fields are only updated
//   on i_load and otherwise hold their last value.
//
//   Ports:
//     clk, reset        : clock, asynchronous active-high reset
//     i_load            : capture the bundle this cycle
//     i_reg_write       : write enable to capture
//     i_reg_dest        : destination register to capture
//     i_data            : writeback data to capture
//     o_wb_valid        : one-cycle valid pulse
//     o_wb_reg_write    : held write enable
//     o_wb_reg_dest     : held destination register
//     o_wb_data         : held writeback data
// ----------------------------------------------------------------------------
module cpu_mem_wb_reg #(
    parameter int REG_WIDTH = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_reg_write,
    input  logic [REG_IDX_W-1:0] i_reg_dest,
    input  logic [REG_WIDTH-1:0] i_data,
    output logic                 o_wb_valid,
    output logic                 o_wb_reg_write,
    output logic [REG_IDX_W-1:0] o_wb_reg_dest,
    output logic [REG_WIDTH-1:0] o_wb_data
);

    logic                 r_valid;
    logic                 r_reg_write;
    logic [REG_IDX_W-1:0] r_reg_dest;
    logic [REG_WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_reg_dest  <= '0;
            r_data      <= '0;
        end else begin
            r_valid <= i_load;
            if (i_load) begin
                r_reg_write <= i_reg_write;
                r_reg_dest  <= i_reg_dest;
                r_data      <= i_data;
            end
        end
    end

    assign o_wb_valid     = r_valid;
    assign o_wb_reg_write = r_reg_write;
    assign o_wb_reg_dest  = r_reg_dest;
    assign o_wb_data      = r_data;

endmodule : cpu_mem_wb_reg

// File: rtl/cpu_commit_stage.sv
// ----------------------------------------------------------------------------
// cpu_commit_stage
//   Memory/commit stage. Accepts the execute-to-commit bundle, performs the
//   data-memory access over a req/ack handshake, resolves branches and
//   registers the writeback bundle.
//
//   Handshakes:
//     Upstream  : a bundle is taken on a cycle where in_valid && in_ready.
//                 in_ready is high only in IDLE; upstream must hold the
//                 bundle while in_ready is low.
//     Data mem  : dmem_req with dmem_we/addr/wdata stays high and stable
//                 until the cycle dmem_ack is seen; dmem_rdata is sampled in
//                 that same cycle. dmem_ack is ignored when no request is
//                 outstanding.
//
//   Ports:
//     clk, reset                       : clock, asynchronous active-high reset
//     in_valid / in_ready              : upstream handshake
//     branch, mem_write, mem_read      : commit controls
//     mem_to_reg, reg_write            : writeback controls
//     add_result                       : branch target
//     alu_result                       : ALU result / memory address
//     zero                             : ALU zero flag
//     rb                               : store data
//     reg_dest                         : destination register
//     dmem_req/we/addr/wdata, dmem_ack, dmem_rdata : data-memory port
//     branch_taken / branch_target     : one-cycle taken-branch pulse + target
//     wb_valid, wb_reg_write, wb_reg_dest, wb_data : writeback bundle
//     dbg_state                        : current FSM state, for observation
// ----------------------------------------------------------------------------
module cpu_commit_stage #(
    parameter int VIRTUAL_ADDR_WIDTH = cpu_pkg::VIRTUAL_ADDR_WIDTH,
    parameter int REG_WIDTH          = cpu_pkg::REG_WIDTH,
    parameter int NUM_REGS           = cpu_pkg::NUM_REGS,
    localparam int REG_IDX_W         = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          branch,
    input  logic                          mem_write,
    input  logic                          mem_read,
    input  logic                          mem_to_reg,
    input  logic                          reg_write,
    input  logic [VIRTUAL_ADDR_WIDTH-1:0] add_result,
    input  logic [REG_WIDTH-1:0]          alu_result,
    input  logic                          zero,
    input  logic [REG_WIDTH-1:0]          rb,
    input  logic [REG_IDX_W-1:0]          reg_dest,
    output logic                          dmem_req,
    output logic                          dmem_we,
    output logic [VIRTUAL_ADDR_WIDTH-1:0] dmem_addr,
    output logic [REG_WIDTH-1:0]          dmem_wdata,
    input  logic                          dmem_ack,
    input  logic [REG_WIDTH-1:0]          dmem_rdata,
    output logic                          branch_taken,
    output logic [VIRTUAL_ADDR_WIDTH-1:0] branch_target,
    output logic                          wb_valid,
    output logic                          wb_reg_write,
    output logic [REG_IDX_W-1:0]          wb_reg_dest,
    output logic [REG_WIDTH-1:0]          wb_data,
    output cpu_pkg::mem_state_e           dbg_state
);

    import cpu_pkg::*;

    commit_t    w_commit;
    writeback_t w_wb_ctl;
    logic       w_accept;
    logic       w_is_mem;

    mem_state_e r_state;
    mem_state_e w_next_state;

    // Bundle captured for an outstanding memory access.
    logic                          r_dmem_we;
    logic [VIRTUAL_ADDR_WIDTH-1:0] r_dmem_addr;
    logic [REG_WIDTH-1:0]          r_dmem_wdata;
    writeback_t                    r_cap_wb;
    logic [REG_IDX_W-1:0]          r_cap_reg_dest;
    logic [REG_WIDTH-1:0]          r_cap_alu;

    logic                          r_branch_taken;
    logic [VIRTUAL_ADDR_WIDTH-1:0] r_branch_target;

    logic                          w_wb_load;
    logic                          w_wb_reg_write;
    logic [REG_IDX_W-1:0]          w_wb_reg_dest;
    logic [REG_WIDTH-1:0]          w_wb_data;

    assign w_commit = '{branch: branch, mem_write: mem_write, mem_read: mem_read};
    assign w_wb_ctl = '{mem_to_reg: mem_to_reg, reg_write: reg_write};

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_is_mem = w_commit.mem_read || w_commit.mem_write;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and writeback source selection
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_wb_load      = 1'b0;
        w_wb_reg_write = w_wb_ctl.reg_write;
        w_wb_reg_dest  = reg_dest;
        w_wb_data      = alu_result;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_mem) begin
                        w_next_state = MEM_WAIT;
                    end else begin
                        w_wb_load = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                w_wb_reg_write = r_cap_wb.reg_write;
                w_wb_reg_dest  = r_cap_reg_dest;
                w_wb_data      = r_cap_wb.mem_to_reg ? dmem_rdata : r_cap_alu;
                if (dmem_ack) begin
                    w_wb_load    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory-access capture. The request itself is the MEM_WAIT state, so
    // an asynchronous reset drops it immediately and abandons the access.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dmem_we      <= 1'b0;
            r_dmem_addr    <= '0;
            r_dmem_wdata   <= '0;
            r_cap_wb       <= '0;
            r_cap_reg_dest <= '0;
            r_cap_alu      <= '0;
        end else if (w_accept && w_is_mem) begin
            r_dmem_we            <= w_commit.mem_write;
            r_dmem_addr          <= alu_result[VIRTUAL_ADDR_WIDTH-1:0];
            r_dmem_wdata         <= rb;
            r_cap_wb.mem_to_reg  <= w_wb_ctl.mem_to_reg;
            // read+write together behaves as a store: no register update
            r_cap_wb.reg_write   <= w_wb_ctl.reg_write &&
                                    !(w_commit.mem_read && w_commit.mem_write);
            r_cap_reg_dest       <= reg_dest;
            r_cap_alu            <= alu_result;
        end
    end

    assign dmem_req   = (r_state == MEM_WAIT);
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;

    // ------------------------------------------------------------------
    // Branch resolution: pulse for one cycle after a taken branch is
    // accepted; the target holds until the next taken branch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
        end else begin
            r_branch_taken <= w_accept && w_commit.branch && zero;
            if (w_accept && w_commit.branch && zero) begin
                r_branch_target <= add_result;
            end
        end
    end

    assign branch_taken  = r_branch_taken;
    assign branch_target = r_branch_target;
    assign dbg_state     = r_state;

    cpu_mem_wb_reg #(
        .REG_WIDTH (REG_WIDTH),
        .REG_IDX_W (REG_IDX_W)
    ) u_wb_reg (
        .clk            (clk),
        .reset          (reset),
        .i_load         (w_wb_load),
        .i_reg_write    (w_wb_reg_write),
        .i_reg_dest     (w_wb_reg_dest),
        .i_data         (w_wb_data),
        .o_wb_valid     (wb_valid),
        .o_wb_reg_write (wb_reg_write),
        .o_wb_reg_dest  (wb_reg_dest),
        .o_wb_data      (wb_data)
    );

endmodule : cpu_commit_stage

// File: tb/tb_cpu_commit_stage.sv
module tb_cpu_commit_stage;

    localparam int VA_W  = 32;
    localparam int REG_W = 32;
    localparam int IDX_W = 5;
    localparam int WB_W  = 1 + IDX_W + REG_W;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    logic              in_valid;
    logic              in_ready;
    logic              branch, mem_write, mem_read, mem_to_reg, reg_write, zero;
    logic [VA_W-1:0]   add_result;
    logic [REG_W-1:0]  alu_result, rb;
    logic [IDX_W-1:0]  reg_dest;
    logic              dmem_req, dmem_we, dmem_ack;
    logic [VA_W-1:0]   dmem_addr;
    logic [REG_W-1:0]  dmem_wdata, dmem_rdata;
    logic              branch_taken;
    logic [VA_W-1:0]   branch_target;
    logic              wb_valid, wb_reg_write;
    logic [IDX_W-1:0]  wb_reg_dest;
    logic [REG_W-1:0]  wb_data;
    cpu_pkg::mem_state_e dbg_state;

    cpu_commit_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .branch        (branch),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .add_result    (add_result),
        .alu_result    (alu_result),
        .zero          (zero),
        .rb            (rb),
        .reg_dest      (reg_dest),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_reg_dest   (wb_reg_dest),
        .wb_data       (wb_data),
        .dbg_state     (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state and checker
    // ------------------------------------------------------------------
    logic [WB_W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_wb  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [WB_W-1:0] wb_entry(input logic rw, input logic [IDX_W-1:0] d,
                                                 input logic [REG_W-1:0] v);
        return {rw, d, v};
    endfunction

    // Writeback monitor: every wb_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            n_wb++;
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 64'(wb_data), 64'hDEAD_0000);
            end else begin
                check("wb_bundle", 64'({wb_reg_write, wb_reg_dest, wb_data}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Present one bundle and hold it until accepted; returns just after the
    // accepting edge with in_valid dropped.
    task automatic send(input logic br, input logic wr, input logic rd, input logic m2r,
                        input logic rw, input logic z, input logic [IDX_W-1:0] dest,
                        input logic [VA_W-1:0] add, input logic [REG_W-1:0] alu,
                        input logic [REG_W-1:0] rbv);
        int n;
        in_valid   = 1'b1;
        branch     = br;
        mem_write  = wr;
        mem_read   = rd;
        mem_to_reg = m2r;
        reg_write  = rw;
        zero       = z;
        reg_dest   = dest;
        add_result = add;
        alu_result = alu;
        rb         = rbv;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        if (!(rd || wr)) exp_q.push_back(wb_entry(rw, dest, alu));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic alu_op(input logic [IDX_W-1:0] dest, input logic [REG_W-1:0] data);
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, dest, '0, data, '0);
    endtask

    // Memory op answered after 'waits' extra request cycles.
    task automatic mem_op(input logic rd, input logic wr, input logic m2r, input logic rw,
                          input logic [IDX_W-1:0] dest, input logic [REG_W-1:0] alu,
                          input logic [REG_W-1:0] rbv, input logic [REG_W-1:0] rdat,
                          input int waits);
        logic exp_rw;
        exp_rw = rw && !(rd && wr);
        send(1'b0, wr, rd, m2r, rw, 1'b0, dest, '0, alu, rbv);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            check("dmem_req_held", 64'(dmem_req), 64'd1);
            check("dmem_we", 64'(dmem_we), 64'(wr));
            check("dmem_addr", 64'(dmem_addr), 64'(alu));
            if (wr) check("dmem_wdata", 64'(dmem_wdata), 64'(rbv));
            check("in_ready_busy", 64'(in_ready), 64'd0);
            if (i == waits) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdat;
                exp_q.push_back(wb_entry(exp_rw, dest, m2r ? rdat : alu));
            end
            @(posedge clk);
            #1;
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom();
        end
        @(negedge clk);
        check("dmem_req_drop", 64'(dmem_req), 64'd0);
        check("in_ready_back", 64'(in_ready), 64'd1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int base;
        reset      = 1'b1;
        in_valid   = 1'b0;
        branch     = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        zero       = 1'b0;
        add_result = '0;
        alu_result = '0;
        rb         = '0;
        reg_dest   = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;

        // Reset values
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_dmem", 64'({dmem_req, dmem_we, dmem_addr, dmem_wdata}), 64'd0);
        check("rst_branch", 64'({branch_taken, branch_target}), 64'd0);
        check("rst_wb", 64'({wb_valid, wb_reg_write, wb_reg_dest, wb_data}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(cpu_pkg::IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ALU op, then confirm the pulse ends and fields hold
        alu_op(5'd5, 32'h1234);
        check("alu_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("wb_valid_drop", 64'(wb_valid), 64'd0);
        check("wb_data_hold", 64'(wb_data), 64'h1234);
        check("wb_dest_hold", 64'(wb_reg_dest), 64'd5);

        // Load with two wait states
        mem_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0, 32'hCAFE, 2);
        // Store with same-cycle ack
        mem_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'h40, 32'hAA55, 32'h0, 0);
        // Read+write together: store, register write suppressed
        mem_op(1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 32'h80, 32'h1357, 32'hBEEF, 1);

        // Branch taken
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h2000, 32'h77, '0);
        check("br_taken", 64'(branch_taken), 64'd1);
        check("br_target", 64'(branch_target), 64'h2000);
        @(posedge clk);
        #1;
        check("br_pulse_once", 64'(branch_taken), 64'd0);
        // Branch not taken
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 32'h3000, 32'h88, '0);
        check("br_not_taken", 64'(branch_taken), 64'd0);
        check("br_target_hold", 64'(branch_target), 64'h2000);
        @(posedge clk);
        #1;

        // Reset in the middle of an access
        send(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, '0, 32'h200, '0);
        @(negedge clk);
        check("mid_req", 64'(dmem_req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_req_drop", 64'(dmem_req), 64'd0);
        check("async_in_ready", 64'(in_ready), 64'd1);
        check("async_wb_valid", 64'(wb_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("post_rst_ready", 64'(in_ready), 64'd1);
        alu_op(5'd9, 32'h5555);
        repeat (2) @(negedge clk);

        // Stray ack in IDLE, then four back-to-back ALU ops
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        check("stray_ack_req", 64'(dmem_req), 64'd0);
        check("stray_ack_ready", 64'(in_ready), 64'd1);
        base = n_wb;
        for (int k = 0; k < 4; k++) begin
            alu_op(5'($urandom_range(0, 31)), $urandom());
            check("b2b_ready", 64'(in_ready), 64'd1);
        end
        repeat (2) @(negedge clk);
        #1;
        check("b2b_wb_count", 64'(n_wb - base), 64'd4);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cpu_commit_stage
